// File: rtl/ad9361_tdd_sequencer.sv
// TDD sync generator/tracker and per-chip ENABLE/TXNRX sequencer for NUM_CHIPS AD9361 devices.
// Requested changes take effect on a shared sync boundary; direction changes are guarded.
module ad9361_tdd_sequencer #(
  parameter int unsigned NUM_CHIPS        = 2,
  parameter bit          MASTER           = 1'b1,
  parameter int unsigned SYNC_PERIOD      = 1000,
  parameter int unsigned SYNC_PULSE_WIDTH = 4,
  parameter int unsigned GUARD_CYCLES     = 16
) (
  input  logic                 axi_aclk,
  input  logic                 axi_areset,
  input  logic [NUM_CHIPS-1:0] up_enable,
  input  logic [NUM_CHIPS-1:0] up_txnrx,
  input  logic                 tdd_sync_i,
  output logic                 tdd_sync_o,
  output logic                 tdd_sync_t,
  output logic [NUM_CHIPS-1:0] enable,
  output logic [NUM_CHIPS-1:0] txnrx,
  output logic [NUM_CHIPS-1:0] busy,
  output logic                 sync_strobe,
  output logic                 sync_lost
);

  localparam int unsigned PW = $clog2(SYNC_PERIOD);
  localparam int unsigned WW = $clog2(SYNC_PULSE_WIDTH + 1);
  localparam int unsigned DW = $clog2(2 * SYNC_PERIOD + 1);
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

  localparam logic [PW-1:0] PeriodLast = PW'(SYNC_PERIOD - 1);
  localparam logic [WW-1:0] PulseLen   = WW'(SYNC_PULSE_WIDTH);
  localparam logic [DW-1:0] WdMax      = DW'(2 * SYNC_PERIOD);
  localparam logic [GW-1:0] GuardLast  = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {StStable, StGuardOff, StGuardOn} chip_state_e;

  // ---------------------------------------------------------------------------------------------
  // Sync boundary generation / tracking
  // ---------------------------------------------------------------------------------------------
  logic [PW-1:0] period_q, period_d;
  logic [WW-1:0] pulse_q, pulse_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [2:0]    sync_meta_q;
  logic          sync_dly_q;
  logic          strobe_q, strobe_d;

  always_comb begin
    period_d = (period_q == PeriodLast) ? '0 : period_q + PW'(1);
    pulse_d  = pulse_q;
    if (period_q == PeriodLast) begin
      pulse_d = PulseLen;
    end else if (pulse_q != '0) begin
      pulse_d = pulse_q - WW'(1);
    end
    // Slave: two synchroniser stages, one delay stage, then a registered rising-edge detect.
    strobe_d = MASTER ? (period_q == PeriodLast) : (sync_meta_q[2] & ~sync_dly_q);
    if (strobe_d) begin
      wd_d = '0;
    end else if (wd_q != WdMax) begin
      wd_d = wd_q + DW'(1);
    end else begin
      wd_d = wd_q;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      period_q    <= '0;
      pulse_q     <= '0;
      wd_q        <= '0;
      sync_meta_q <= '0;
      sync_dly_q  <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      period_q    <= period_d;
      pulse_q     <= pulse_d;
      wd_q        <= wd_d;
      sync_meta_q <= {sync_meta_q[1:0], tdd_sync_i};
      sync_dly_q  <= sync_meta_q[2];
      strobe_q    <= strobe_d;
    end
  end

  assign sync_strobe = strobe_q;
  assign tdd_sync_o  = MASTER & (pulse_q != '0);
  assign tdd_sync_t  = ~MASTER;
  assign sync_lost   = ~MASTER & (wd_q == WdMax);

  // ---------------------------------------------------------------------------------------------
  // Per-chip sequencers
  // ---------------------------------------------------------------------------------------------
  chip_state_e          state_q [NUM_CHIPS];
  chip_state_e          state_d [NUM_CHIPS];
  logic [GW-1:0]        guard_q [NUM_CHIPS];
  logic [GW-1:0]        guard_d [NUM_CHIPS];
  logic [NUM_CHIPS-1:0] en_q, en_d, dir_q, dir_d, busy_q, busy_d;
  logic [NUM_CHIPS-1:0] pend_en_q, pend_en_d, pend_dir_q, pend_dir_d;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      for (int i = 0; i < NUM_CHIPS; i++) begin
        state_q[i] <= StStable;
        guard_q[i] <= '0;
      end
      en_q       <= '0;
      dir_q      <= '0;
      busy_q     <= '0;
      pend_en_q  <= '0;
      pend_dir_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHIPS; i++) begin
        state_q[i] <= state_d[i];
        guard_q[i] <= guard_d[i];
      end
      en_q       <= en_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      pend_en_q  <= pend_en_d;
      pend_dir_q <= pend_dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      unique case (state_q[i])
        StStable: begin
          if (strobe_q && (up_txnrx[i] != dir_q[i])) state_d[i] = StGuardOff;
        end
        StGuardOff: begin
          if (guard_q[i] == GuardLast) state_d[i] = StGuardOn;
        end
        StGuardOn: begin
          if (guard_q[i] == GuardLast) state_d[i] = StStable;
        end
        default: state_d[i] = StStable;
      endcase
    end
  end

  always_comb begin
    guard_d    = guard_q;
    en_d       = en_q;
    dir_d      = dir_q;
    pend_en_d  = pend_en_q;
    pend_dir_d = pend_dir_q;
    busy_d     = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      busy_d[i] = (state_d[i] != StStable);
      unique case (state_q[i])
        StStable: begin
          if (strobe_q) begin
            if (up_txnrx[i] != dir_q[i]) begin
              // Pending values are frozen here until the sequence returns to stable.
              pend_en_d[i]  = up_enable[i];
              pend_dir_d[i] = up_txnrx[i];
              en_d[i]       = 1'b0;
              guard_d[i]    = '0;
            end else begin
              en_d[i] = up_enable[i];
            end
          end
        end
        StGuardOff: begin
          if (guard_q[i] == GuardLast) begin
            guard_d[i] = '0;
            dir_d[i]   = pend_dir_q[i];
          end else begin
            guard_d[i] = guard_q[i] + GW'(1);
          end
        end
        StGuardOn: begin
          if (guard_q[i] == GuardLast) begin
            guard_d[i] = '0;
            en_d[i]    = pend_en_q[i];
          end else begin
            guard_d[i] = guard_q[i] + GW'(1);
          end
        end
        default: guard_d[i] = '0;
      endcase
    end
  end

  assign enable = en_q;
  assign txnrx  = dir_q;
  assign busy   = busy_q;

endmodule

// File: doc/ad9361_tdd_sequencer.md
# ad9361_tdd_sequencer

Parametrised TDD sync and ENABLE/TXNRX sequencer for NUM_CHIPS AD9361 devices, generalising the per-chip enable_x/txnrx_x/up_enable_x/up_txnrx_x/tdd_sync_x wiring of the dual-chip PL wrapper into one block. Requested enable/txnrx changes are applied only on a common sync boundary, so all chips switch together. A TX/RX direction change passes through a guarded disable → switch → re-enable sequence. The block either generates the sync pulse (master) or tracks an external one (slave). It sits in the PL wrapper between the GPIO-driven up_* controls and the AD9361 control pins.

## Interface
- NUM_CHIPS, 2, number of AD9361 devices (≥1)
- MASTER, 1, 1 = generate tdd_sync_o; 0 = follow tdd_sync_i
- SYNC_PERIOD, 1000, axi_aclk cycles between sync boundaries (≥8)
- SYNC_PULSE_WIDTH, 4, master sync pulse width in cycles (1..SYNC_PERIOD-1)
- GUARD_CYCLES, 16, cycles per guard interval (≥1)

- axi_aclk  in  1  single clock for all logic
- axi_areset  in  1  asynchronous, active-high reset
- up_enable  in  NUM_CHIPS  requested ENABLE per chip; synchronous to axi_aclk
- up_txnrx  in  NUM_CHIPS  requested TXNRX per chip; synchronous to axi_aclk
- tdd_sync_i  in  1  external sync; asynchronous; used only when MASTER=0
- tdd_sync_o  out  1  generated sync pulse; 0 when MASTER=0
- tdd_sync_t  out  1  pad tristate: constant 0 if MASTER=1, constant 1 if MASTER=0
- enable  out  NUM_CHIPS  ENABLE pin per chip
- txnrx  out  NUM_CHIPS  TXNRX pin per chip
- busy  out  NUM_CHIPS  chip is in a guarded transition
- sync_strobe  out  1  one-cycle pulse marking each sync boundary
- sync_lost  out  1  slave watchdog flag; 0 when MASTER=1

## Operation
- Reset values: enable=0, txnrx=0, busy=0, sync_strobe=0, tdd_sync_o=0, sync_lost=0, all counters 0, all chip FSMs in STABLE.
- Master sync generation:
  - Period counter runs 0..SYNC_PERIOD-1 and wraps.
  - sync_strobe is registered. It is high the cycle after the counter equals SYNC_PERIOD-1.
  - tdd_sync_o is high for SYNC_PULSE_WIDTH cycles, starting in the same cycle as sync_strobe.
- Slave sync tracking:
  - tdd_sync_i passes through a 2-FF synchroniser, then a registered rising-edge detect drives sync_strobe.
  - Watchdog counter clears on each sync_strobe and saturates at 2*SYNC_PERIOD.
  - sync_lost=1 while the watchdog is saturated. It clears on the next sync_strobe.
- Per-chip FSM (NUM_CHIPS independent copies, all driven by the shared sync_strobe):
  - STABLE, on sync_strobe:
    - up_txnrx==txnrx and up_enable≠enable: set enable=up_enable; stay in STABLE.
    - up_txnrx≠txnrx: latch pend_en=up_enable and pend_dir=up_txnrx; set enable=0; go to GUARD_OFF.
    - otherwise: no change.
  - GUARD_OFF: guard counter counts GUARD_CYCLES cycles, then set txnrx=pend_dir and go to GUARD_ON.
  - GUARD_ON: counts GUARD_CYCLES cycles, then set enable=pend_en and go to STABLE.
  - busy = (state ≠ STABLE), registered together with the state.
- up_* changes while not in STABLE are ignored until the chip is back in STABLE and the next sync_strobe arrives. The latched pend_* values are never overwritten mid-sequence.
- sync_strobe pulses during GUARD_OFF/GUARD_ON are ignored by that chip.
- Asserting axi_areset mid-sequence immediately forces every output to its reset value and returns every FSM to STABLE.

## Timing
- Master: counting cycle 1 as the first rising edge after reset release, the first sync_strobe occurs in cycle SYNC_PERIOD, then every SYNC_PERIOD cycles.
- Slave: sync_strobe occurs 3 axi_aclk cycles after the first edge that samples tdd_sync_i high. A level held high gives exactly one strobe.
- Enable-only change: enable updates in cycle T+1, where T is the sync_strobe cycle.
- Direction change:
  - enable=0 at T+1.
  - txnrx toggles at T+1+GUARD_CYCLES.
  - enable=pend_en at T+1+2*GUARD_CYCLES.
  - busy is high from T+1 through T+2*GUARD_CYCLES inclusive.
- If 2*GUARD_CYCLES+1 ≥ SYNC_PERIOD, a sequence spans sync boundaries. The next request is served on the first sync_strobe after busy falls.
- Up to NUM_CHIPS chips may start sequences on the same strobe. Chips that start together have cycle-identical output edges.

## Test plan
- Master, defaults, up_enable=2'b11 set at cycle 10 → enable=2'b11 first appears in cycle 1001; tdd_sync_o is high in cycles 1000–1003 and 2000–2003.
- Direction change: txnrx=0, enable=1, then up_txnrx=2'b11 → at strobe T, enable=0 at T+1, txnrx=1 at T+17, enable=1 at T+33, busy high T+1..T+32.
- Request toggled mid-sequence: up_txnrx back to 0 at T+5 → current sequence completes with txnrx=1; reverse sequence starts at the following strobe.
- Slave (MASTER=0): tdd_sync_i pulse at cycle 100 → sync_strobe in cycle 103; no further pulse → sync_lost=1 from cycle 2103 until the next edge; tdd_sync_t=1 throughout.
- axi_areset asserted at T+20 during GUARD_ON → enable=0, txnrx=0, busy=0 immediately; after release, first master strobe occurs SYNC_PERIOD cycles later.
- NUM_CHIPS=4, chips 0 and 3 change direction and chip 1 changes enable only on the same strobe → chips 0 and 3 have identical edges; chip 1 enable updates at T+1.
